// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS sequencing controller.
// Latency: n/a (types, constants and encodings only).
// Backpressure: n/a.
//
// Contents: FSM state enum, opcode/funct/rt constants, ALU/writeback
// encodings, instruction-class enum and the packed control bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_ILLEGAL,
        CL_ADDU,
        CL_SUBU,
        CL_ORI,
        CL_LUI,
        CL_ADDI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BLTZAL,
        CL_J,
        CL_JAL,
        CL_JR
    } iclass_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_ADDU   = 6'b100001;
    localparam logic [5:0] FN_SUBU   = 6'b100011;
    localparam logic [5:0] FN_JR     = 6'b001000;

    // REGIMM rt selector
    localparam logic [4:0] RT_BLTZAL = 5'b10000;

    // ALU control
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_LUI   = 2'b11;

    // Writeback source
    localparam logic [2:0] RSRC_ALU  = 3'b000;
    localparam logic [2:0] RSRC_MEM  = 3'b001;
    localparam logic [2:0] RSRC_PC4  = 3'b010;

    // Writeback destination
    localparam logic [1:0] RDST_RT   = 2'b00;
    localparam logic [1:0] RDST_RD   = 2'b01;
    localparam logic [1:0] RDST_R31  = 2'b10;

    // Control bundle driven towards the datapath.
    typedef struct packed {
        logic       mem_req;
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_ctl;
        logic       ext_op;
        logic       alu_src;
        logic [2:0] reg_src;
        logic [1:0] reg_dst;
        logic       npc_sel;
        logic       j_ctl;
        logic       jr_ctl;
        logic       bltzal;
    } ctl_t;

    // R-type ALU ops write rd; the immediate forms write rt.
    function automatic logic writes_rd(input iclass_t c);
        return (c == CL_ADDU) || (c == CL_SUBU);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct/rt -> instruction class.
// Latency: 0 cycles (pure combinational; the FSM registers the result in DECODE).
// Backpressure: none.
//
// Ports: i_opcode[5:0], i_funct[5:0], i_rt[4:0] in; o_class (iclass_t) out.
// Anything not recognised comes out as CL_ILLEGAL.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    output iclass_t    o_class
);

    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_class = CL_ADDU;
                    FN_SUBU: o_class = CL_SUBU;
                    FN_JR:   o_class = CL_JR;
                    default: o_class = CL_ILLEGAL;
                endcase
            end
            // Only the linking form of REGIMM is supported.
            OP_REGIMM: o_class = (i_rt == RT_BLTZAL) ? CL_BLTZAL : CL_ILLEGAL;
            OP_J:      o_class = CL_J;
            OP_JAL:    o_class = CL_JAL;
            OP_BEQ:    o_class = CL_BEQ;
            OP_ADDI:   o_class = CL_ADDI;
            OP_ORI:    o_class = CL_ORI;
            OP_LUI:    o_class = CL_LUI;
            OP_LW:     o_class = CL_LW;
            OP_SW:     o_class = CL_SW;
            default:   o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore sequencing controller for the MIPS datapath (fetch/decode/exec/mem/wb).
// Latency: ALU ops 4, lw 5, sw 4, branch/jump 3 cycles with mem_ready high.
// Backpressure: FETCH, MEM_RD and MEM_WR hold mem_req and stall until mem_ready.
//
// Ports: clk, rst (sync, active-high); opcode/funct/rt from the IR; zero,
// positive, overflow from the ALU; mem_ready from memory. Outputs: mem_req,
// pc/ir/mem/reg write enables, alu_ctl, ext_op, alu_src, reg_src, reg_dst,
// npc_sel, j_ctl, jr_ctl, bltzal, exc, retired[CNT_W-1:0].
// Build option: define MC_OVERFLOW_TRAP_EN to trap addi overflow into a
// sticky TRAP state (exc=1 until reset); otherwise addi wraps and exc is 0.
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       rt,
    input  logic             zero,
    input  logic             positive,
    input  logic             overflow,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_ctl,
    output logic             ext_op,
    output logic             alu_src,
    output logic [2:0]       reg_src,
    output logic [1:0]       reg_dst,
    output logic             npc_sel,
    output logic             j_ctl,
    output logic             jr_ctl,
    output logic             bltzal,
    output logic             exc,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    iclass_t          r_class;
    logic [CNT_W-1:0] r_retired;

    iclass_t          w_class;
    logic             w_retire;
    ctl_t             w_ctl;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .i_rt     (rt),
        .o_class  (w_class)
    );

    // Commit points: every terminal state retires unconditionally except
    // MEM_WR, which only completes once memory accepts the store.
    assign w_retire = (r_state == ST_WB_ALU) || (r_state == ST_WB_MEM) ||
                      (r_state == ST_BRANCH) || (r_state == ST_JUMP)   ||
                      ((r_state == ST_MEM_WR) && mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_class   <= CL_ILLEGAL;
            r_retired <= '0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_class <= w_class;
                    case (w_class)
                        CL_ADDU, CL_SUBU, CL_ORI, CL_LUI,
                        CL_ADDI, CL_LW, CL_SW:         r_state <= ST_EXEC;
                        CL_BEQ, CL_BLTZAL:             r_state <= ST_BRANCH;
                        CL_J, CL_JAL, CL_JR:           r_state <= ST_JUMP;
                        default:                       r_state <= ST_FETCH;
                    endcase
                end
                ST_EXEC: begin
                    if (r_class == CL_LW) begin
                        r_state <= ST_MEM_RD;
                    end else if (r_class == CL_SW) begin
                        r_state <= ST_MEM_WR;
`ifdef MC_OVERFLOW_TRAP_EN
                    end else if ((r_class == CL_ADDI) && overflow) begin
                        r_state <= ST_TRAP;
`endif
                    end else begin
                        r_state <= ST_WB_ALU;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ready) r_state <= ST_WB_MEM;
                end
                ST_MEM_WR: begin
                    if (mem_ready) r_state <= ST_FETCH;
                end
                ST_WB_ALU, ST_WB_MEM,
                ST_BRANCH, ST_JUMP:   r_state <= ST_FETCH;
                // Sticky until reset.
                ST_TRAP:              r_state <= ST_TRAP;
                default:              r_state <= ST_FETCH;
            endcase
        end
    end

    // Moore decode from state + latched class; only the FETCH/MEM_WR enables
    // and the branch outcome look at live inputs.
    always_comb begin
        w_ctl = '0;
        case (r_state)
            ST_FETCH: begin
                w_ctl.mem_req  = 1'b1;
                w_ctl.ir_write = mem_ready;
                w_ctl.pc_write = mem_ready;
            end
            ST_EXEC: begin
                case (r_class)
                    CL_SUBU: w_ctl.alu_ctl = ALU_SUB;
                    CL_ORI:  w_ctl.alu_ctl = ALU_OR;
                    CL_LUI:  w_ctl.alu_ctl = ALU_LUI;
                    default: w_ctl.alu_ctl = ALU_ADD;
                endcase
                w_ctl.alu_src = (r_class == CL_ORI) || (r_class == CL_LUI) ||
                                (r_class == CL_ADDI) || (r_class == CL_LW) ||
                                (r_class == CL_SW);
                w_ctl.ext_op  = (r_class == CL_ADDI) || (r_class == CL_LW) ||
                                (r_class == CL_SW);
            end
            ST_MEM_RD: begin
                w_ctl.mem_req = 1'b1;
            end
            ST_MEM_WR: begin
                w_ctl.mem_req   = 1'b1;
                w_ctl.mem_write = mem_ready;
            end
            ST_WB_ALU: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.reg_src   = RSRC_ALU;
                w_ctl.reg_dst   = writes_rd(r_class) ? RDST_RD : RDST_RT;
            end
            ST_WB_MEM: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.reg_src   = RSRC_MEM;
                w_ctl.reg_dst   = RDST_RT;
            end
            ST_BRANCH: begin
                w_ctl.alu_ctl = ALU_SUB;
                if (r_class == CL_BLTZAL) begin
                    // Link happens whether or not the branch is taken.
                    w_ctl.bltzal    = 1'b1;
                    w_ctl.reg_write = 1'b1;
                    w_ctl.reg_dst   = RDST_R31;
                    w_ctl.reg_src   = RSRC_PC4;
                    w_ctl.pc_write  = !positive && !zero;
                    w_ctl.npc_sel   = !positive && !zero;
                end else begin
                    w_ctl.pc_write  = zero;
                    w_ctl.npc_sel   = zero;
                end
            end
            ST_JUMP: begin
                w_ctl.pc_write = 1'b1;
                w_ctl.jr_ctl   = (r_class == CL_JR);
                w_ctl.j_ctl    = (r_class != CL_JR);
                if (r_class == CL_JAL) begin
                    w_ctl.reg_write = 1'b1;
                    w_ctl.reg_dst   = RDST_R31;
                    w_ctl.reg_src   = RSRC_PC4;
                end
            end
            default: w_ctl = '0;
        endcase
        // Reset silences the datapath in the same cycle it is asserted.
        if (rst) begin
            w_ctl = '0;
        end
    end

    assign mem_req   = w_ctl.mem_req;
    assign pc_write  = w_ctl.pc_write;
    assign ir_write  = w_ctl.ir_write;
    assign mem_write = w_ctl.mem_write;
    assign reg_write = w_ctl.reg_write;
    assign alu_ctl   = w_ctl.alu_ctl;
    assign ext_op    = w_ctl.ext_op;
    assign alu_src   = w_ctl.alu_src;
    assign reg_src   = w_ctl.reg_src;
    assign reg_dst   = w_ctl.reg_dst;
    assign npc_sel   = w_ctl.npc_sel;
    assign j_ctl     = w_ctl.j_ctl;
    assign jr_ctl    = w_ctl.jr_ctl;
    assign bltzal    = w_ctl.bltzal;
    assign retired   = rst ? '0 : r_retired;

`ifdef MC_OVERFLOW_TRAP_EN
    assign exc = (r_state == ST_TRAP) && !rst;
`else
    // Overflow has no consumer when trapping is compiled out.
    logic w_unused_overflow;
    assign w_unused_overflow = overflow;
    assign exc = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected control vectors are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_mc_controller;

    localparam int CNT_W = 4;   // small so the retire counter wraps

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode, funct;
    logic [4:0]       rt;
    logic             zero, positive, overflow, mem_ready;
    logic             mem_req, pc_write, ir_write, mem_write, reg_write;
    logic [1:0]       alu_ctl;
    logic             ext_op, alu_src;
    logic [2:0]       reg_src;
    logic [1:0]       reg_dst;
    logic             npc_sel, j_ctl, jr_ctl, bltzal, exc;
    logic [CNT_W-1:0] retired;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .rt        (rt),
        .zero      (zero),
        .positive  (positive),
        .overflow  (overflow),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .alu_ctl   (alu_ctl),
        .ext_op    (ext_op),
        .alu_src   (alu_src),
        .reg_src   (reg_src),
        .reg_dst   (reg_dst),
        .npc_sel   (npc_sel),
        .j_ctl     (j_ctl),
        .jr_ctl    (jr_ctl),
        .bltzal    (bltzal),
        .exc       (exc),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, pc_write, ir_write, mem_write, reg_write;
        logic [1:0] alu_ctl;
        logic       ext_op, alu_src;
        logic [2:0] reg_src;
        logic [1:0] reg_dst;
        logic       npc_sel, j_ctl, jr_ctl, bltzal, exc;
    } vec_t;

    typedef struct packed {
        vec_t             c;
        logic [CNT_W-1:0] ret;
        logic [15:0]      id;
    } exp_t;

    exp_t             sb_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               step_id = 0;
    logic [CNT_W-1:0] exp_ret;

    function automatic vec_t v(input logic mr, pw, iw, mw, rw,
                               input logic [1:0] alu, input logic ext, src,
                               input logic [2:0] rs, input logic [1:0] rd,
                               input logic npc, j, jr, bl, ex);
        v = {mr, pw, iw, mw, rw, alu, ext, src, rs, rd, npc, j, jr, bl, ex};
    endfunction

    localparam vec_t ZV = '0;

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic step(input vec_t e, input bit retire);
        exp_t x;
        x.c   = e;
        x.ret = exp_ret;
        x.id  = step_id[15:0];
        sb_q.push_back(x);
        step_id++;
        @(posedge clk);
        #1;
        if (retire) exp_ret = exp_ret + 1'b1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
        opcode = op;
        funct  = fn;
        rt     = r;
    endtask

    task automatic do_fetch(input int stalls);
        for (int i = 0; i < stalls; i++) begin
            mem_ready = 1'b0;
            step(v(Y,N,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        end
        mem_ready = 1'b1;
        step(v(Y,Y,Y,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b0);
    endtask

    // mem_ready is driven low here: DECODE must not wait on memory.
    task automatic do_decode();
        mem_ready = 1'b0;
        step(ZV, 1'b0);
    endtask

    task automatic alu_op(input logic [5:0] op, input logic [5:0] fn, input int stalls,
                          input logic [1:0] alu, input logic src, input logic ext,
                          input logic [1:0] dst);
        set_ir(op, fn, 5'd0);
        do_fetch(stalls);
        do_decode();
        mem_ready = 1'b1;
        step(v(N,N,N,N,N, alu,ext,src, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        mem_ready = 1'b0;
        step(v(N,N,N,N,Y, 2'b00,N,N, 3'b000,dst, N,N,N,N,N), 1'b1);
    endtask

    task automatic do_lw(input int stalls);
        set_ir(6'b100011, 6'd0, 5'd0);
        do_fetch(0);
        do_decode();
        step(v(N,N,N,N,N, 2'b00,Y,Y, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        for (int i = 0; i < stalls; i++) begin
            mem_ready = 1'b0;
            step(v(Y,N,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        end
        mem_ready = 1'b1;
        step(v(Y,N,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        step(v(N,N,N,N,Y, 2'b00,N,N, 3'b001,2'b00, N,N,N,N,N), 1'b1);
    endtask

    task automatic do_sw(input int stalls);
        set_ir(6'b101011, 6'd0, 5'd0);
        do_fetch(0);
        do_decode();
        step(v(N,N,N,N,N, 2'b00,Y,Y, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        for (int i = 0; i < stalls; i++) begin
            mem_ready = 1'b0;
            step(v(Y,N,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        end
        mem_ready = 1'b1;
        step(v(Y,N,N,Y,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b1);
    endtask

    // Branches and jumps: FETCH, DECODE, then one resolving cycle that retires.
    task automatic br_jmp(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                          input logic z, input logic p, input vec_t e);
        set_ir(op, fn, r);
        do_fetch(0);
        do_decode();
        zero     = z;
        positive = p;
        mem_ready = 1'b1;
        step(e, 1'b1);
        zero     = 1'b0;
        positive = 1'b0;
    endtask

    task automatic illegal(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
        set_ir(op, fn, r);
        do_fetch(0);
        do_decode();
    endtask

    task automatic reset_cycles(input int n);
        rst       = 1'b1;
        mem_ready = 1'b1;
        exp_ret   = '0;
        for (int i = 0; i < n; i++) step(ZV, 1'b0);
        rst       = 1'b0;
    endtask

    // Monitor: pops one expectation per cycle and compares the live outputs.
    always @(negedge clk) begin
        exp_t x;
        vec_t a;
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            a = {mem_req, pc_write, ir_write, mem_write, reg_write, alu_ctl, ext_op,
                 alu_src, reg_src, reg_dst, npc_sel, j_ctl, jr_ctl, bltzal, exc};
            n_cmp++;
            if (a !== x.c) begin
                n_bad++;
                $display("FAIL ctl step%0d got=%b expected=%b", x.id, a, x.c);
            end
            n_cmp++;
            if (retired !== x.ret) begin
                n_bad++;
                $display("FAIL retired step%0d got=%0d expected=%0d", x.id, retired, x.ret);
            end
        end
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; positive = 1'b0; overflow = 1'b0;
        set_ir(6'd0, 6'd0, 5'd0);
        exp_ret = '0;
        @(posedge clk);
        #1;

        reset_cycles(2);

        // ALU ops: addu/subu to rd, ori/lui/addi to rt.
        alu_op(6'b000000, 6'b100001, 0, 2'b00, N, N, 2'b01);
        alu_op(6'b000000, 6'b100011, 2, 2'b01, N, N, 2'b01);
        alu_op(6'b001101, 6'd0,      0, 2'b10, Y, N, 2'b00);
        alu_op(6'b001111, 6'd0,      1, 2'b11, Y, N, 2'b00);
        alu_op(6'b001000, 6'd0,      0, 2'b00, Y, Y, 2'b00);

        do_lw(2);
        do_sw(1);

        // beq taken / not taken
        br_jmp(6'b000100, 6'd0, 5'd0, Y, N, v(N,Y,N,N,N, 2'b01,N,N, 3'b000,2'b00, Y,N,N,N,N));
        br_jmp(6'b000100, 6'd0, 5'd0, N, N, v(N,N,N,N,N, 2'b01,N,N, 3'b000,2'b00, N,N,N,N,N));
        // bltzal taken, then link-only for positive and for zero
        br_jmp(6'b000001, 6'd0, 5'b10000, N, N, v(N,Y,N,N,Y, 2'b01,N,N, 3'b010,2'b10, Y,N,N,Y,N));
        br_jmp(6'b000001, 6'd0, 5'b10000, N, Y, v(N,N,N,N,Y, 2'b01,N,N, 3'b010,2'b10, N,N,N,Y,N));
        br_jmp(6'b000001, 6'd0, 5'b10000, Y, N, v(N,N,N,N,Y, 2'b01,N,N, 3'b010,2'b10, N,N,N,Y,N));
        // j, jal, jr
        br_jmp(6'b000010, 6'd0, 5'd0, N, N, v(N,Y,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,Y,N,N,N));
        br_jmp(6'b000011, 6'd0, 5'd0, N, N, v(N,Y,N,N,Y, 2'b00,N,N, 3'b010,2'b10, N,Y,N,N,N));
        br_jmp(6'b000000, 6'b001000, 5'd0, N, N, v(N,Y,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,Y,N,N));

        // Illegal encodings fall straight back to FETCH, nothing retires.
        illegal(6'b111111, 6'd0, 5'd0);
        illegal(6'b000001, 6'd0, 5'b00000);
        illegal(6'b000000, 6'b100000, 5'd0);

        // Fifteen retired so far; three more cross the 4-bit wrap.
        for (int i = 0; i < 3; i++) alu_op(6'b000000, 6'b100001, 0, 2'b00, N, N, 2'b01);

        // addi with overflow
        set_ir(6'b001000, 6'd0, 5'd0);
        do_fetch(0);
        do_decode();
        overflow = 1'b1;
        step(v(N,N,N,N,N, 2'b00,Y,Y, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        overflow = 1'b0;
`ifdef MC_OVERFLOW_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            step(v(N,N,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,Y), 1'b0);
        end
        reset_cycles(1);
`else
        step(v(N,N,N,N,Y, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b1);
`endif

        // Reset in the middle of a stalled store: no mem_write, count cleared.
        set_ir(6'b101011, 6'd0, 5'd0);
        do_fetch(0);
        do_decode();
        step(v(N,N,N,N,N, 2'b00,Y,Y, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        mem_ready = 1'b0;
        step(v(Y,N,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b0);
        reset_cycles(1);
        // First instruction after reset: FETCH immediately, count restarts at 0.
        alu_op(6'b000000, 6'b100001, 0, 2'b00, N, N, 2'b01);
        step(v(Y,N,N,N,N, 2'b00,N,N, 3'b000,2'b00, N,N,N,N,N), 1'b0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d expected=0 pending", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
